// File: rtl/seg7_stopwatch_core_pkg.sv
// Shared types and segment encodings for the seven-segment stopwatch.
package seg7_stopwatch_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam int NUM_BTN   = 2;
    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high a..g with bit0=a
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_stopwatch_core_btn_edge.sv
// Raw button conditioning: 2-FF synchroniser followed by a rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn,
    output logic pulse
);
    logic sync1, sync2, prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else if (ena) begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/seg7_stopwatch_core.sv
// Seconds stopwatch (00..59 BCD) with start/stop/clear FSM and a two-digit
// multiplexed, registered seven-segment output.
module seg7_stopwatch_core
    import seg7_stopwatch_core_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int SCAN_DIV = 10_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start_btn,
    input  logic       clear_btn,
    output logic [6:0] segments,
    output logic       dp,
    output logic [1:0] digit_sel,
    output logic       running,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw, btn_ev;
    logic               start_ev, clear_ev;

    assign btn_raw[BTN_START] = start_btn;
    assign btn_raw[BTN_CLEAR] = clear_btn;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_edge u_btn (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena),
            .btn  (btn_raw[g]),
            .pulse(btn_ev[g])
        );
    end

    assign start_ev = btn_ev[BTN_START];
    assign clear_ev = btn_ev[BTN_CLEAR];

    state_t          state;
    logic [PW-1:0]   pre;
    logic [3:0]      ones;
    logic [2:0]      tens;
    logic [SW-1:0]   scan_cnt;
    logic            tick, at_59;
    logic [1:0]      next_sel;
    logic [6:0]      next_seg;

    assign tick  = (state == S_RUN) && (pre == PRE_MAX);
    assign at_59 = (ones == 4'd9) && (tens == 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            running <= 1'b0;
            pre     <= '0;
            ones    <= '0;
            tens    <= '0;
            wrap    <= 1'b0;
        end else if (ena) begin
            wrap <= 1'b0;
            if (clear_ev) begin
                // Clear beats a coincident start and drops any fractional second
                state   <= S_IDLE;
                running <= 1'b0;
                pre     <= '0;
                ones    <= '0;
                tens    <= '0;
            end else begin
                case (state)
                    S_IDLE:  if (start_ev) begin state <= S_RUN;   running <= 1'b1; end
                    S_RUN:   if (start_ev) begin state <= S_PAUSE; running <= 1'b0; end
                    S_PAUSE: if (start_ev) begin state <= S_RUN;   running <= 1'b1; end
                    default: begin state <= S_IDLE; running <= 1'b0; end
                endcase

                if (state == S_IDLE)
                    pre <= '0;
                else if (state == S_RUN)
                    pre <= tick ? '0 : pre + 1'b1;

                if (tick) begin
                    if (at_59) begin
                        ones <= '0;
                        tens <= '0;
                        wrap <= 1'b1;
                    end else if (ones == 4'd9) begin
                        ones <= '0;
                        tens <= tens + 3'd1;
                    end else begin
                        ones <= ones + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        next_sel = (scan_cnt == SCAN_MAX) ? {digit_sel[0], digit_sel[1]} : digit_sel;
        if (next_sel[0])
            next_seg = seg_decode(ones);
        else if (BLANK_LZ && (tens == 3'd0))
            next_seg = SEG_BLANK;
        else
            next_seg = seg_decode({1'b0, tens});
    end

    // Strobe and segment data share an edge so the display never shows a torn digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'b01;
            segments  <= SEG_BLANK;
            dp        <= 1'b0;
        end else if (ena) begin
            scan_cnt  <= (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + 1'b1;
            digit_sel <= next_sel;
            segments  <= next_seg;
            dp        <= next_sel[0] && running && (pre < PRE_HALF);
        end
    end

endmodule

// File: tb/tb_seg7_stopwatch_core.sv
// Randomised bench for seg7_stopwatch_core against a seconds/phase reference model.
module tb_seg7_stopwatch_core;
    localparam int TD = 10;
    localparam int SD = 4;
    localparam int CODE [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    logic       clk = 1'b0;
    logic       rst, ena, start_btn, clear_btn;
    logic [6:0] segments;
    logic       dp, running, wrap;
    logic [1:0] digit_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_stopwatch_core #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start_btn(start_btn), .clear_btn(clear_btn),
        .segments(segments), .dp(dp), .digit_sel(digit_sel), .running(running), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: mode 0=stopped/cleared, 1=counting, 2=held; secs is elapsed seconds
    int m_mode, m_pre, m_secs, m_edges;
    int e_seg, e_dp, e_sel, e_wrap;
    bit sq[$];
    bit cq[$];

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_secs = 0; m_edges = 0;
        e_seg = 0; e_dp = 0; e_sel = 1; e_wrap = 0;
        sq = '{0, 0, 0};
        cq = '{0, 0, 0};
    endtask

    task automatic model_edge();
        bit sev, cev, tick, was_run;
        int slot, old_pre;
        if (!ena) return;
        // An event fires two enabled edges after the button is first seen high
        sev = sq[1] && !sq[0];
        cev = cq[1] && !cq[0];
        sq.push_back(start_btn); void'(sq.pop_front());
        cq.push_back(clear_btn); void'(cq.pop_front());
        tick    = (m_mode == 1) && (m_pre == TD - 1);
        was_run = (m_mode == 1);
        old_pre = m_pre;
        m_edges++;
        slot  = (m_edges / SD) % 2;
        e_sel = (slot == 0) ? 1 : 2;
        if (slot == 0) e_seg = CODE[m_secs % 10];
        else           e_seg = (m_secs / 10 == 0) ? 0 : CODE[m_secs / 10];
        e_dp = (slot == 0 && was_run && old_pre < TD / 2) ? 1 : 0;
        if (cev) begin
            m_mode = 0; m_pre = 0; m_secs = 0; e_wrap = 0;
        end else begin
            e_wrap = (tick && m_secs == 59) ? 1 : 0;
            if (tick) m_secs = (m_secs + 1) % 60;
            if (m_mode == 0)      m_pre = 0;
            else if (m_mode == 1) m_pre = (m_pre + 1) % TD;
            if (sev) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    task automatic check_outs();
        chk("segments",  segments,  e_seg);
        chk("digit_sel", digit_sel, e_sel);
        chk("dp",        dp,        e_dp);
        chk("running",   running,   (m_mode == 1) ? 1 : 0);
        chk("wrap",      wrap,      e_wrap);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic mid_reset();
        start_btn = 1'b0; clear_btn = 1'b0; ena = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_segments",  segments,  0);
        chk("rst_digit_sel", digit_sel, 1);
        chk("rst_running",   running,   0);
        chk("rst_dp",        dp,        0);
        chk("rst_wrap",      wrap,      0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, got;
        rst = 1'b1; ena = 1'b1; start_btn = 1'b0; clear_btn = 1'b0;
        model_reset();
        #1 check_outs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) cyc();

        // First start: RUN should show up on the third edge after the press
        start_btn = 1'b1;
        n = 0;
        while (!running && n < 10) begin
            cyc();
            n++;
            if (n == 2) start_btn = 1'b0;
        end
        start_btn = 1'b0;
        chk("run_latency", n, 3);

        got = 0;
        for (int i = 0; i < 800 && got == 0; i++) begin
            cyc();
            if (wrap) got = 1;
        end
        chk("wrap_seen", got, 1);
        cyc();
        chk("wrap_one_cycle", wrap, 0);

        // Pause, hold, resume
        start_btn = 1'b1; repeat (2) cyc(); start_btn = 1'b0;
        repeat (20) cyc();
        chk("paused", running, 0);
        start_btn = 1'b1; repeat (2) cyc(); start_btn = 1'b0;
        repeat (25) cyc();
        chk("resumed", running, 1);

        // Coincident start and clear
        start_btn = 1'b1; clear_btn = 1'b1; repeat (2) cyc();
        start_btn = 1'b0; clear_btn = 1'b0;
        repeat (3) cyc();
        chk("clear_wins", running, 0);
        repeat (10) cyc();

        // Enable drop mid-run, then an asynchronous reset
        start_btn = 1'b1; repeat (2) cyc(); start_btn = 1'b0;
        repeat (30) cyc();
        ena = 1'b0; repeat (50) cyc(); ena = 1'b1;
        repeat (7) cyc();
        mid_reset();
        repeat (10) cyc();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0)  start_btn = ~start_btn;
            if ($urandom_range(0, 199) == 0) clear_btn = ~clear_btn;
            ena = ($urandom_range(0, 15) != 0);
            cyc();
        end
        mid_reset();
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
